conv_operand_loader: RTL
========================

// Module: conv_operand_loader
// PURPOSE
//  Producer side of the Convolution operand interface. Takes a serial 4-bit element stream.
//  Assembles 32-element IFM and weight frames into the 128-bit parallel vectors the
//  convolution engine samples. Emits one-cycle in_valid / weight_valid pulses only when the
//  engine is idle. Sits between the host/DMA stream and the Convolution block.
// PARAMETERS
//  ELEM_W       4   bits per element
//  NUM_ELEM     32  elements per frame (16 per channel x 2 channels)
//  HOLD_CYCLES  53  cycles the engine stays busy after an in_valid pulse
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  s_valid      in   1        stream beat valid
//  s_ready      out  1        loader can accept a beat; a beat transfers when s_valid&&s_ready
//  s_is_weight  in   1        1 = beat belongs to a weight frame, 0 = IFM frame
//  s_data       in   ELEM_W   element value, unsigned
//  in_valid     out  1        one-cycle pulse: ifm_vec is valid
//  weight_valid out  1        one-cycle pulse: weight_vec is valid
//  ifm_vec      out  NUM_ELEM*ELEM_W  element k (k=0..31) at bits [4k+3:4k]; k=0 drives In_IFM_1
//  weight_vec   out  NUM_ELEM*ELEM_W  same packing; k=0 drives In_Weight_1
//  frame_err    out  1        one-cycle pulse: frame type changed mid-frame
// BEHAVIOUR
//  Reset: all outputs 0. s_ready 0 during reset and 1 after. Collect count 0, pending slot empty, busy 0.
//  Collect: each accepted beat writes element[cnt], then cnt++.
//   - The first beat latches the frame type.
//   - The 32nd beat (cnt==31) completes the frame and sets cnt to 0.
//  Type mismatch: an accepted beat with s_is_weight != latched type while cnt>0 discards the partial frame.
//   - That beat becomes element 0 of a new frame of the new type.
//   - frame_err pulses on the next cycle.
//  Pending slot: one frame deep, holds data and type bit.
//   - A completed frame moves into the slot on the same edge as its 32nd beat.
//   - This requires the slot to be empty or being issued on that edge.
//  s_ready = !(cnt==31 && pending_full && !issue), where issue is the current-cycle issue condition.
//  Issue: condition is pending_full && busy==0. On the next edge:
//   - IFM frame: ifm_vec <= slot, in_valid <= 1, busy <= HOLD_CYCLES.
//   - Weight frame: weight_vec <= slot, weight_valid <= 1, busy unchanged (stays 0).
//   - In both cases the slot is cleared.
//  Pulses last exactly one cycle. in_valid and weight_valid are never high together.
//  ifm_vec and weight_vec hold their last issued value until the next issue of the same type.
//  Busy: decrements by 1 per cycle while nonzero. With busy!=0, no issue of either type.
//   - A weight change during EXE would corrupt the engine's MUL stage.
//   - Minimum spacing between in_valid pulses is HOLD_CYCLES+1 = 54 cycles.
//  Ordering: frames issue strictly in completion order.
//  Latency: 32nd beat accepted at edge t with busy==0 and the slot free gives the pulse high in cycle t+1.
//  Simultaneous events: a frame completing on the same edge the slot issues goes into the slot.
//  s_ready stays 1 in that case.
//  Reset mid-frame or mid-busy: partial frame, pending slot and busy timer are discarded.
//  No pulse is generated after reset deasserts.
// STRUCTURE
//  Shared package conv_pkg:
//   - ELEM_W, NUM_ELEM, HOLD_CYCLES
//   - frame type enum {FT_IFM=0, FT_WEIGHT=1}
//   - vector width localparam VEC_W = NUM_ELEM*ELEM_W
//  Sub-module conv_frame_collector holds cnt, the element buffer and the latched type.
//   - Outputs frame_done, frame_type, frame_data and err.
//  The top level holds the pending slot, busy timer, issue logic and output registers.
// TESTING
//  1. 32 weight beats (values 1..15,0 repeating), busy=0 -> weight_valid pulses 1 cycle after the 32nd beat.
//     weight_vec[3:0]==1 and weight_vec[127:124]==0.
//  2. IFM frame all 4'hF issued, then a second IFM frame completed 5 cycles later.
//     -> second in_valid exactly 54 cycles after the first. s_ready drops at cnt==31 until the slot frees.
//  3. 10 IFM beats then a weight beat -> frame_err pulse 1 cycle later.
//     The following 31 weight beats complete a weight frame with element 0 = the mismatching beat.
//  4. Weight frame completed while busy=20 -> weight_valid only after busy reaches 0, and never during busy.
//  5. rst_n low for 1 cycle at cnt=17 with a pending IFM -> no in_valid.
//     A fresh 32-beat frame issues normally afterwards.
//  6. Back-to-back: completion edge coincides with issue edge.
//     -> no stall, no lost frame, order preserved (W then IFM gives weight_valid before in_valid).

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : conv_pkg                                                       |
// | Purpose  : Shared sizes and frame-type encoding for the conv operand path |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package conv_pkg;

    localparam int ELEM_W      = 4;
    localparam int NUM_ELEM    = 32;
    localparam int HOLD_CYCLES = 53;
    localparam int VEC_W       = NUM_ELEM * ELEM_W;
    localparam int CNT_W       = $clog2(NUM_ELEM);
    localparam int BUSY_W      = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {
        FT_IFM    = 1'b0,
        FT_WEIGHT = 1'b1
    } frame_type_e;

endpackage
`default_nettype wire

// File: rtl/conv_frame_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv_frame_collector                                           |
// | Purpose  : Assembles serial elements into one frame, flags type changes   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_frame_collector
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               beat,
    input  frame_type_e        beat_type,
    input  logic [ELEM_W-1:0]  beat_data,
    output logic               at_last,
    output logic               frame_done,
    output frame_type_e        frame_type,
    output logic [VEC_W-1:0]   frame_data,
    output logic               err
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_ELEM - 1);

    logic [CNT_W-1:0]          r_cnt;
    frame_type_e               r_type;
    logic [VEC_W-ELEM_W-1:0]   r_buf;
    logic                      r_err;
    logic                      w_mismatch;
    logic [CNT_W-1:0]          w_wr_idx;

    // A type change restarts the frame with the offending beat as element 0
    assign w_mismatch = beat && (r_cnt != '0) && (beat_type != r_type);
    assign w_wr_idx   = w_mismatch ? '0 : r_cnt;

    assign at_last    = (r_cnt == c_last_idx);
    assign frame_done = beat && !w_mismatch && (r_cnt == c_last_idx);
    assign frame_type = r_type;
    assign frame_data = {beat_data, r_buf};
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_type <= FT_IFM;
            r_buf  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_mismatch;
            if (beat) begin
                if (w_wr_idx == '0) begin
                    r_type <= beat_type;
                end
                if (w_wr_idx != c_last_idx) begin
                    r_buf[int'(w_wr_idx)*ELEM_W +: ELEM_W] <= beat_data;
                end
                r_cnt <= (w_wr_idx == c_last_idx) ? '0 : w_wr_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv_operand_loader                                            |
// | Purpose  : Streams IFM/weight frames into the convolution engine vectors  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_operand_loader
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_is_weight,
    input  logic [ELEM_W-1:0]  s_data,
    output logic               in_valid,
    output logic               weight_valid,
    output logic [VEC_W-1:0]   ifm_vec,
    output logic [VEC_W-1:0]   weight_vec,
    output logic               frame_err
);

    logic               w_beat;
    logic               w_at_last;
    logic               w_frame_done;
    frame_type_e        w_frame_type;
    logic [VEC_W-1:0]   w_frame_data;
    logic               w_issue;

    logic               r_pend_full;
    frame_type_e        r_pend_type;
    logic [VEC_W-1:0]   r_pend_data;
    logic [BUSY_W-1:0]  r_busy;

    assign w_issue = r_pend_full && (r_busy == '0);
    // Only the completing beat needs the slot; it may land as the slot drains
    assign s_ready = rst_n && !(w_at_last && r_pend_full && !w_issue);
    assign w_beat  = s_valid && s_ready;

    conv_frame_collector u_collector (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat       (w_beat),
        .beat_type  (frame_type_e'(s_is_weight)),
        .beat_data  (s_data),
        .at_last    (w_at_last),
        .frame_done (w_frame_done),
        .frame_type (w_frame_type),
        .frame_data (w_frame_data),
        .err        (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_full  <= 1'b0;
            r_pend_type  <= FT_IFM;
            r_pend_data  <= '0;
            r_busy       <= '0;
            in_valid     <= 1'b0;
            weight_valid <= 1'b0;
            ifm_vec      <= '0;
            weight_vec   <= '0;
        end else begin
            in_valid     <= 1'b0;
            weight_valid <= 1'b0;

            // Weight issue leaves the timer idle; only IFM occupies the engine
            if (w_issue) begin
                if (r_pend_type == FT_IFM) begin
                    ifm_vec  <= r_pend_data;
                    in_valid <= 1'b1;
                    r_busy   <= BUSY_W'(HOLD_CYCLES);
                end else begin
                    weight_vec   <= r_pend_data;
                    weight_valid <= 1'b1;
                end
            end else if (r_busy != '0) begin
                r_busy <= r_busy - 1'b1;
            end

            if (w_frame_done) begin
                r_pend_data <= w_frame_data;
                r_pend_type <= w_frame_type;
                r_pend_full <= 1'b1;
            end else if (w_issue) begin
                r_pend_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
